// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// supported opcodes, funct3 values, ALU operation classes and ALU codes.
package riscv_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_SLT = 3'b010;
    localparam logic [F3_W-1:0] F3_OR  = 3'b110;
    localparam logic [F3_W-1:0] F3_AND = 3'b111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode.
// Ports: i_alu_op (operation class from FSM), i_funct3, i_op5 (opcode bit 5,
// set only for R-type among ALU ops), i_funct7b5; o_alu_control_c (combinational).
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [ALUOP_W-1:0]  i_alu_op,
    input  logic [F3_W-1:0]     i_funct3,
    input  logic                i_op5,
    input  logic                i_funct7b5,
    output logic [ALUCTL_W-1:0] o_alu_control_c
);

    // funct7b5 selects sub only for R-type; for I-type it is immediate bits
    always_comb begin
        o_alu_control_c = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB:   o_alu_control_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    F3_ADD:  o_alu_control_c = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  o_alu_control_c = ALU_SLT;
                    F3_OR:   o_alu_control_c = ALU_OR;
                    F3_AND:  o_alu_control_c = ALU_AND;
                    default: o_alu_control_c = ALU_ADD;
                endcase
            end
            default:     o_alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit (lw, sw, R/I ALU, beq, jal).
// Inputs: clk, rst (async active-high), op/funct3/funct7b5 from IR, zero
// from ALU, mem_ready from memory. Outputs: mem_req, adr_src, write strobes,
// datapath mux selects, alu_control, imm_src and sticky illegal. Outputs are
// decoded from the state register; ir_write/pc_write follow mem_ready/zero.
module multicycle_control
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     op,
    input  logic [F3_W-1:0]     funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                pc_write,
    output logic [SEL_W-1:0]    result_src,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    imm_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal
);

    state_t               r_state;
    state_t               w_next;
    logic [ALUOP_W-1:0]   w_alu_op;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        w_alu_op   = ALUOP_ADD;
        illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                w_alu_op  = ALUOP_SUB;
                pc_write  = zero;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // State is already FETCH under reset; only the strobes need masking
        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            illegal   = 1'b0;
        end
    end

    // Immediate format select, independent of state
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct3        (funct3),
        .i_op5           (op[5]),
        .i_funct7b5      (funct7b5),
        .o_alu_control_c (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is modelled as its list of
// steps; wait-capable steps repeat while mem_ready is low.
module tb_multicycle_control;

    localparam int ST_F   = 0;
    localparam int ST_D   = 1;
    localparam int ST_MA  = 2;
    localparam int ST_MR  = 3;
    localparam int ST_MWB = 4;
    localparam int ST_MWR = 5;
    localparam int ST_ER  = 6;
    localparam int ST_EI  = 7;
    localparam int ST_AW  = 8;
    localparam int ST_B   = 9;
    localparam int ST_J   = 10;
    localparam int ST_IL  = 11;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       mem_req, adr_src, mem_write, ir_write, reg_write, pc_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } outs_t;

    int n_tests = 0;
    int n_fail  = 0;
    int seq[$];

    int r_cycles, r_mw, r_rw_cnt, r_rw_cyc, r_rs_rw, r_alu_ex, r_pcw_b, r_ill, r_strobe;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .pc_write(pc_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
        .illegal(illegal)
    );

    function automatic void build_seq(input logic [6:0] o);
        seq.delete();
        seq.push_back(ST_F);
        seq.push_back(ST_D);
        case (o)
            LW:  begin seq.push_back(ST_MA); seq.push_back(ST_MR); seq.push_back(ST_MWB); end
            SW:  begin seq.push_back(ST_MA); seq.push_back(ST_MWR); end
            RT:  begin seq.push_back(ST_ER); seq.push_back(ST_AW); end
            IT:  begin seq.push_back(ST_EI); seq.push_back(ST_AW); end
            BEQ: seq.push_back(ST_B);
            JAL: begin seq.push_back(ST_J); seq.push_back(ST_AW); end
            default: for (int i = 0; i < 10; i++) seq.push_back(ST_IL);
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input int st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7);
        logic [2:0] r;
        r = 3'b000;
        if (st == ST_B) r = 3'b001;
        else if (st == ST_ER || st == ST_EI) begin
            case (f3)
                3'b000:  r = (o[5] && f7) ? 3'b001 : 3'b000;
                3'b010:  r = 3'b101;
                3'b110:  r = 3'b011;
                3'b111:  r = 3'b010;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    function automatic outs_t expect_outs(input int st_in, input logic mr, input logic z,
                                          input logic rst_on, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7);
        outs_t e;
        int    st;
        e  = '0;
        st = rst_on ? ST_F : st_in;
        e.imm_src     = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        e.alu_control = exp_alu(st, o, f3, f7);
        case (st)
            ST_F:   begin e.mem_req = 1'b1; e.src_b = 2'b10; e.result_src = 2'b10;
                          e.ir_write = mr; e.pc_write = mr; end
            ST_D:   begin e.src_a = 2'b01; e.src_b = 2'b01; end
            ST_MA:  begin e.src_a = 2'b10; e.src_b = 2'b01; end
            ST_MR:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
            ST_MWB: begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            ST_MWR: begin e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1; end
            ST_ER:  e.src_a = 2'b10;
            ST_EI:  begin e.src_a = 2'b10; e.src_b = 2'b01; end
            ST_AW:  e.reg_write = 1'b1;
            ST_B:   begin e.src_a = 2'b10; e.pc_write = z; end
            ST_J:   begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1; end
            ST_IL:  e.illegal = 1'b1;
            default: ;
        endcase
        if (rst_on) begin
            e.mem_req = 1'b0; e.ir_write = 1'b0; e.pc_write = 1'b0;
            e.reg_write = 1'b0; e.mem_write = 1'b0; e.illegal = 1'b0;
        end
        return e;
    endfunction

    function automatic outs_t sample_dut();
        outs_t a;
        a.mem_req = mem_req; a.adr_src = adr_src; a.mem_write = mem_write;
        a.ir_write = ir_write; a.reg_write = reg_write; a.pc_write = pc_write;
        a.illegal = illegal; a.result_src = result_src; a.src_a = alu_src_a;
        a.src_b = alu_src_b; a.imm_src = imm_src; a.alu_control = alu_control;
        return a;
    endfunction

    task automatic check_cycle(input int st, input string name);
        outs_t e, a;
        e = expect_outs(st, mem_ready, zero, rst, op, funct3, funct7b5);
        a = sample_dut();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t step=%0d op=%b got=%h expected=%h", name, $time, st, op, a, e);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge. mode 0: random mem_ready;
    // mode 1: mem_ready high except n_wait cycles in MEMWRITE.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int mode, input int n_wait, input int zmode,
                             input int max_cyc, input string name);
        int idx, waited, st;
        build_seq(o);
        idx = 0; waited = 0;
        r_cycles = 0; r_mw = 0; r_rw_cnt = 0; r_rw_cyc = -1; r_rs_rw = -1;
        r_alu_ex = -1; r_pcw_b = -1; r_ill = 0; r_strobe = 0;
        op = o; funct3 = f3; funct7b5 = f7;
        while (idx < seq.size() && r_cycles < max_cyc) begin
            st = seq[idx];
            if (mode == 0) mem_ready = ($urandom_range(0, 99) < 70);
            else           mem_ready = !(st == ST_MWR && waited < n_wait);
            if (st == ST_MWR && !mem_ready) waited++;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_cycle(st, name);
            if (mem_write) r_mw++;
            if (reg_write) begin r_rw_cnt++; r_rw_cyc = r_cycles + 1; r_rs_rw = int'(result_src); end
            if (st == ST_ER || st == ST_EI) r_alu_ex = int'(alu_control);
            if (st == ST_B) r_pcw_b = int'(pc_write);
            if (illegal) r_ill++;
            if (st == ST_IL) r_strobe += int'(mem_req | mem_write | ir_write | reg_write | pc_write);
            @(posedge clk);
            if (!((st == ST_F || st == ST_MR || st == ST_MWR) && !mem_ready)) idx++;
            r_cycles++;
            @(negedge clk);
        end
        if (idx < seq.size() && max_cyc >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout after %0d cycles", name, r_cycles);
        end
    endtask

    // Asynchronous reset mid-cycle; entered and left on a falling edge
    task automatic reset_pulse(input string name);
        #2 rst = 1'b1;
        #1;
        check_cycle(ST_F, name);
        check_lit({name, "_illegal"}, int'(illegal), 0);
        @(posedge clk);
        #1;
        check_cycle(ST_F, {name, "_hold"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] ops[7];
        logic [6:0] bad[4];
        logic [6:0] o;
        int         mc;
        ops = '{LW, SW, RT, IT, BEQ, JAL, 7'b0000000};
        bad = '{7'b0000000, 7'b0010111, 7'b0110111, 7'b1111111};

        rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check_cycle(ST_F, "reset");
        check_lit("reset_result_src", int'(result_src), 2);
        check_lit("reset_mem_req", int'(mem_req), 0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(LW, 3'b010, 1'b0, 1, 0, 0, 200, "lw");
        check_lit("lw_cycles", r_cycles, 5);
        check_lit("lw_regwrite_count", r_rw_cnt, 1);
        check_lit("lw_regwrite_cycle", r_rw_cyc, 5);
        check_lit("lw_result_src", r_rs_rw, 1);

        run_instr(SW, 3'b010, 1'b0, 1, 3, 0, 200, "sw_wait");
        check_lit("sw_memwrite_cycles", r_mw, 4);
        check_lit("sw_cycles", r_cycles, 7);
        mem_ready = 1'b0;
        #1;
        check_cycle(ST_F, "sw_then_fetch");
        check_lit("sw_then_fetch_lit", int'(mem_req && !adr_src && !mem_write), 1);
        @(negedge clk);

        run_instr(RT, 3'b000, 1'b1, 1, 0, 0, 200, "sub");
        check_lit("sub_alu_control", r_alu_ex, 1);
        run_instr(IT, 3'b000, 1'b1, 1, 0, 0, 200, "addi_f7");
        check_lit("addi_alu_control", r_alu_ex, 0);
        check_lit("addi_cycles", r_cycles, 4);

        run_instr(BEQ, 3'b000, 1'b0, 1, 0, 1, 200, "beq_taken");
        check_lit("beq_taken_pcw", r_pcw_b, 1);
        check_lit("beq_cycles", r_cycles, 3);
        run_instr(BEQ, 3'b000, 1'b0, 1, 0, 0, 200, "beq_not_taken");
        check_lit("beq_not_taken_pcw", r_pcw_b, 0);

        run_instr(JAL, 3'b000, 1'b0, 1, 0, 0, 200, "jal");
        check_lit("jal_cycles", r_cycles, 4);

        run_instr(7'b0000000, 3'b000, 1'b0, 1, 0, 0, 200, "illegal");
        check_lit("illegal_sticky_cycles", r_ill, 10);
        check_lit("illegal_strobes", r_strobe, 0);
        reset_pulse("illegal_reset");

        // Reset while a store is waiting on memory
        run_instr(SW, 3'b010, 1'b0, 1, 5, 0, 5, "sw_partial");
        check_lit("sw_partial_in_memwrite", int'(mem_write), 1);
        reset_pulse("midaccess_reset");

        for (int n = 0; n < 80; n++) begin
            o  = ops[$urandom_range(0, 6)];
            if (o == 7'b0000000) o = bad[$urandom_range(0, 3)];
            mc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 200;
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0, 2, mc, "random");
            if (mc < 200 || (o != LW && o != SW && o != RT && o != IT && o != BEQ && o != JAL))
                reset_pulse("random_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: none; the block is fixed to the RV32I subset lw, sw, R-type ALU, I-type ALU, beq, jal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op  input  7  opcode from instruction register (IR[6:0]).
REQ-005 funct3  input  3  IR[14:12].
REQ-006 funct7b5  input  1  IR[30].
REQ-007 zero  input  1  ALU zero flag, same cycle.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 mem_req  output  1  memory access requested this cycle.
REQ-010 adr_src  output  1  0 = PC, 1 = ALU-result register as memory address.
REQ-011 mem_write, ir_write, reg_write, pc_write  output  1 each  write strobes.
REQ-012 result_src, alu_src_a, alu_src_b, imm_src  output  2 each  datapath mux selects.
REQ-013 alu_control  output  3  ALU operation code.
REQ-014 illegal  output  1  unsupported opcode decoded; sticky.

Function
REQ-015 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
REQ-016 Transitions: FETCH->DECODE on mem_ready, else stay; DECODE->MEMADR (op 0000011/0100011), EXECR (0110011), EXECI (0010011), BEQ (1100011), JAL (1101111), otherwise ILLEGAL.
REQ-017 MEMADR->MEMREAD if op=0000011, else MEMWRITE; MEMREAD->MEMWB on mem_ready; MEMWRITE->FETCH on mem_ready; both stay otherwise.
REQ-018 MEMWB->FETCH; EXECR/EXECI->ALUWB; ALUWB->FETCH; BEQ->FETCH; JAL->ALUWB; ILLEGAL->ILLEGAL until reset.
REQ-019 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready.
REQ-020 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
REQ-021 MEMREAD: mem_req=1, adr_src=1, result_src=00. MEMWB: result_src=01, reg_write=1.
REQ-022 MEMWRITE: mem_req=1, adr_src=1, mem_write=1 held for every wait cycle until mem_ready.
REQ-023 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. ALUWB: result_src=00, reg_write=1.
REQ-024 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
REQ-025 Unlisted outputs in any state are 0; ILLEGAL drives all strobes and mem_req 0, illegal=1.
REQ-026 alu_control: alu_op 00->000 (add); 01->001 (sub); 10 by funct3: 000->001 if op[5]&funct7b5 else 000; 010->101 (slt); 110->011 (or); 111->010 (and); other funct3->000.
REQ-027 imm_src combinational from op: 0100011->01, 1100011->10, 1101111->11, all others 00.
REQ-028 Latency without wait states: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4; each mem_ready=0 cycle adds one.

Reset
REQ-029 rst=1 forces state FETCH immediately, independent of clk, including mid-access.
REQ-030 While rst=1: mem_req, ir_write, pc_write, reg_write, mem_write, illegal = 0; mux selects at FETCH values.
REQ-031 First FETCH after rst deasserts is sampled on the first rising edge with rst=0.

Structure
REQ-032 Shared package riscv_pkg holds state enum, opcode constants, alu_op and alu_control encodings.
REQ-033 One sub-module alu_decoder (alu_op, funct3, op[5], funct7b5 -> alu_control); FSM and imm decode stay in top.

Verification
REQ-034 lw x1,4(x0), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5 with result_src=01.
REQ-035 sw with mem_ready low 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH.
REQ-036 sub (funct3=000, funct7b5=1, op=0110011) -> alu_control=001 in EXECR; funct7b5=1 with op=0010011 -> 000.
REQ-037 beq with zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH next cycle.
REQ-038 op=0000000 -> ILLEGAL, illegal=1 sticky for 10 cycles, all strobes 0; rst pulse mid-state -> FETCH within same cycle, illegal=0.
